c_bram_drain: RTL and testbench



---
 rtl/f_stage_pkg.sv | 15 +
 rtl/c_drain_fifo.sv | 68 ++++++
 rtl/c_bram_drain.sv | 107 ++++++++++
 tb/tb_c_bram_drain.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/f_stage_pkg.sv
// Constants and state encoding shared by the F-stage controller and the C BRAM drain.
package f_stage_pkg;

  localparam int unsigned C_DATA_W   = 16;
  localparam int unsigned C_ADDR_W   = 8;
  localparam int unsigned C_BRAM_LAT = 2;

  typedef enum logic [1:0] {
    DRAIN_IDLE,
    DRAIN_ISSUE,
    DRAIN_FLUSH,
    DRAIN_DONE
  } drain_state_e;

endpackage

// File: rtl/c_drain_fifo.sv
// Skid FIFO for the C BRAM drain: registered head, count/full/empty, synchronous clear.
module c_drain_fifo import f_stage_pkg::*; #(
  parameter  int unsigned DATA_W = C_DATA_W,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] head_q;
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              do_push, do_pop;

  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = head_q;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  // Head register tracks mem[rd]; it only moves on a pop or on a push into an emptying FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else if (clr_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      if (do_push) wr_q <= inc(wr_q);
      if (do_pop)  rd_q <= inc(rd_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: ;
      endcase
      if (do_pop && cnt_q > CNT_W'(1))
        head_q <= mem_q[inc(rd_q)];
      else if (do_push && (empty_o || (do_pop && cnt_q == CNT_W'(1))))
        head_q <= din_i;
    end
  end

endmodule

// File: rtl/c_bram_drain.sv
// Streams the C BRAM result vector out over valid/ready once the F stage completes.
module c_bram_drain import f_stage_pkg::*; #(
  parameter int unsigned DATA_W     = C_DATA_W,
  parameter int unsigned ADDR_W     = C_ADDR_W,
  parameter int unsigned BRAM_LAT   = C_BRAM_LAT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              idle,
  input  logic              F_done,
  input  logic [ADDR_W:0]   len,
  output logic              C_bram_En,
  output logic [ADDR_W-1:0] C_bram_addr,
  input  logic [DATA_W-1:0] C_bram_dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              drain_done
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  drain_state_e        state_q;
  logic                fdone_q;
  logic [LEN_W-1:0]    len_q, addr_q, acc_q, acc_d;
  logic [BRAM_LAT-1:0] vld_q;
  logic [CNT_W-1:0]    fifo_cnt;
  logic                fifo_full, fifo_empty;
  logic                start, credit_ok, issue, last_issue, beat;
  int unsigned         inflight;

  always_comb begin
    inflight = 0;
    for (int unsigned i = 0; i < BRAM_LAT; i++) inflight += 32'(vld_q[i]);
  end

  assign start      = F_done && !fdone_q;
  assign credit_ok  = (inflight + 32'(fifo_cnt) < FIFO_DEPTH) && !fifo_full;
  assign issue      = (state_q == DRAIN_ISSUE) && credit_ok && !idle;
  assign last_issue = issue && (addr_q == len_q - LEN_W'(1));
  assign beat       = m_valid && m_ready;
  assign acc_d      = acc_q + LEN_W'(beat);

  assign C_bram_En   = issue;
  assign C_bram_addr = addr_q[ADDR_W-1:0];
  assign m_valid     = !fifo_empty;
  assign m_last      = m_valid && (acc_q == len_q - LEN_W'(1));
  assign busy        = (state_q == DRAIN_ISSUE) || (state_q == DRAIN_FLUSH);
  assign drain_done  = (state_q == DRAIN_DONE);

  // fdone_q resets high so an F_done level held across reset is not taken as a fresh edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DRAIN_IDLE;
      fdone_q <= 1'b1;
      len_q   <= '0;
      addr_q  <= '0;
      acc_q   <= '0;
      vld_q   <= '0;
    end else begin
      fdone_q <= F_done;
      if (idle) begin
        state_q <= DRAIN_IDLE;
        len_q   <= '0;
        addr_q  <= '0;
        acc_q   <= '0;
        vld_q   <= '0;
      end else begin
        vld_q <= (vld_q << 1) | BRAM_LAT'(issue);
        if (issue) addr_q <= addr_q + LEN_W'(1);
        if (beat)  acc_q  <= acc_d;
        case (state_q)
          DRAIN_IDLE: if (start) begin
            len_q   <= len;
            addr_q  <= '0;
            acc_q   <= '0;
            state_q <= (len == '0) ? DRAIN_DONE : DRAIN_ISSUE;
          end
          DRAIN_ISSUE: if (last_issue) state_q <= DRAIN_FLUSH;
          DRAIN_FLUSH: if (inflight == 0 && acc_d == len_q) state_q <= DRAIN_DONE;
          default: ;
        endcase
      end
    end
  end

  c_drain_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .clr_i   (idle),
    .push_i  (vld_q[BRAM_LAT-1]),
    .din_i   (C_bram_dout),
    .pop_i   (beat),
    .head_o  (m_data),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_c_bram_drain.sv
// Scoreboard bench for c_bram_drain with a registered BRAM model.
module tb_c_bram_drain;
  import f_stage_pkg::*;

  localparam int unsigned DW    = C_DATA_W;
  localparam int unsigned AW    = C_ADDR_W;
  localparam int unsigned LAT   = C_BRAM_LAT;
  localparam int unsigned DEPTH = 4;

  logic          clk, rst, idle, F_done, C_bram_En, m_valid, m_ready, m_last, busy, drain_done;
  logic [AW:0]   len;
  logic [AW-1:0] C_bram_addr;
  logic [DW-1:0] C_bram_dout, m_data;

  c_bram_drain #(
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .BRAM_LAT   (LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .idle        (idle),
    .F_done      (F_done),
    .len         (len),
    .C_bram_En   (C_bram_En),
    .C_bram_addr (C_bram_addr),
    .C_bram_dout (C_bram_dout),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last),
    .busy        (busy),
    .drain_done  (drain_done)
  );

  logic [DW-1:0] mem  [1 << AW];
  logic [DW-1:0] pipe [LAT];
  int            issue_cnt [1 << AW];
  logic [DW:0]   exp_q [$];
  logic [DW:0]   mon_e;
  logic [DW-1:0] prev_data;
  logic          stall_prev, stalled;
  int checks, errors, cyc, t_start;
  int beats, en_cnt, valid_cyc, first_valid, done_cyc, first_beat, last_beat;
  int first_en_addr, max_cnt, ovf, en_mid, g, bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // BRAM model: address sampled at the edge, data out LAT edges later.
  assign C_bram_dout = pipe[LAT-1];
  initial begin
    for (int i = 0; i < LAT; i++) pipe[i] = '0;
    forever begin
      @(posedge clk);
      for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= mem[C_bram_addr];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    stall_prev = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (C_bram_En) begin
          if (en_cnt == 0) first_en_addr = int'(C_bram_addr);
          en_cnt++;
          issue_cnt[C_bram_addr]++;
        end
        if (m_valid) begin
          valid_cyc++;
          if (first_valid < 0) first_valid = cyc;
        end
        if (stall_prev && m_valid) chk("hold", m_data, prev_data);
        stall_prev = m_valid && !m_ready;
        prev_data  = m_data;
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) chk("sb_underflow", exp_q.size(), 1);
          else begin
            mon_e = exp_q.pop_front();
            chk("data", m_data, mon_e[DW-1:0]);
            chk("last", m_last, mon_e[DW]);
          end
          if (beats == 0) first_beat = cyc;
          last_beat = cyc;
          beats++;
        end
        if (drain_done && done_cyc < 0) done_cyc = cyc;
        if (int'(dut.fifo_cnt) > max_cnt) max_cnt = int'(dut.fifo_cnt);
        if (dut.u_fifo.push_i && dut.u_fifo.full_o && !dut.u_fifo.pop_i) ovf++;
      end
    end
  end

  task automatic clear_mon();
    exp_q.delete();
    beats = 0; en_cnt = 0; valid_cyc = 0; first_valid = -1; done_cyc = -1;
    first_beat = -1; last_beat = -1; first_en_addr = -1; max_cnt = 0;
    foreach (issue_cnt[i]) issue_cnt[i] = 0;
  endtask

  task automatic start_drain(input int n);
    clear_mon();
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), DW'(32'h0100 + i)});
    @(posedge clk); #1;
    len     = (AW + 1)'(n);
    F_done  = 1;
    t_start = cyc + 1;
  endtask

  task automatic wait_done(input int budget);
    int w = 0;
    while (!drain_done && w < budget) begin
      @(negedge clk);
      w++;
    end
    #1;
    if (!drain_done) chk("done_timeout", drain_done, 1);
  endtask

  task automatic finish_drain();
    @(posedge clk); #1;
    F_done = 0;
    idle   = 1;
    @(posedge clk); #1;
    idle = 0;
    @(negedge clk);
    chk("idle_clr_done", drain_done, 0);
  endtask

  initial begin
    checks = 0; errors = 0; ovf = 0;
    rst = 0; idle = 0; F_done = 0; m_ready = 0; len = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(32'h0100 + i);
    clear_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out", {m_valid, m_last, C_bram_En, busy, drain_done, m_data, C_bram_addr}, '0);
    @(posedge clk); #1;
    rst = 1;
    repeat (2) @(posedge clk);

    // len=8, ready held high
    m_ready = 1;
    start_drain(8);
    @(negedge clk); chk("busy_pre", busy, 0);
    @(negedge clk); chk("busy_issue", busy, 1);
    wait_done(40);
    chk("t1_first_valid", first_valid - t_start, 3);
    chk("t1_done_time", done_cyc - t_start, 11);
    chk("t1_beats", beats, 8);
    chk("t1_no_bubble", last_beat - first_beat, 7);
    chk("t1_sb_empty", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    chk("t1_done_hold", drain_done, 1);
    finish_drain();

    // len=8, ready toggling with a 10-cycle stall at beat 3
    start_drain(8);
    stalled = 0; g = 0;
    while (done_cyc < 0 && g < 300) begin
      @(posedge clk); #1;
      g++;
      if (beats == 3 && !stalled) begin
        stalled = 1;
        m_ready = 0;
        repeat (5) @(posedge clk); #1;
        en_mid = en_cnt;
        repeat (5) @(posedge clk); #1;
        chk("t2_en_stall", en_cnt, en_mid);
        chk("t2_stall_nobeat", beats, 3);
      end else m_ready = ~m_ready;
    end
    if (done_cyc < 0) chk("t2_done", drain_done, 1);
    chk("t2_beats", beats, 8);
    chk("t2_sb_empty", exp_q.size(), 0);
    chk("t2_fifo_max_le_depth", max_cnt <= DEPTH, 1);
    m_ready = 1;
    finish_drain();

    // len=0
    start_drain(0);
    wait_done(20);
    chk("t3_done_time", done_cyc - t_start, 0);
    chk("t3_no_en", en_cnt, 0);
    chk("t3_no_valid", valid_cyc, 0);
    finish_drain();

    // len=256, full address space
    start_drain(256);
    wait_done(400);
    chk("t4_done_time", done_cyc - t_start, 259);
    chk("t4_en_cnt", en_cnt, 256);
    bad = 0;
    foreach (issue_cnt[i]) if (issue_cnt[i] != 1) bad++;
    chk("t4_addr_once", bad, 0);
    chk("t4_beats", beats, 256);
    chk("t4_no_bubble", last_beat - first_beat, 255);
    chk("t4_sb_empty", exp_q.size(), 0);
    finish_drain();

    // idle pulsed after 3 beats, then restart from address 0
    start_drain(8);
    g = 0;
    while (beats < 3 && g < 40) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk); #1;
    idle = 1; m_ready = 0;
    @(posedge clk); #1;
    idle = 0;
    @(negedge clk);
    chk("t5_valid_clr", m_valid, 0);
    chk("t5_en_clr", C_bram_En, 0);
    chk("t5_done_clr", drain_done, 0);
    chk("t5_beats", beats, 3);
    F_done = 0; m_ready = 1;
    @(posedge clk); #1;
    start_drain(5);
    wait_done(40);
    chk("t5_restart_addr", first_en_addr, 0);
    chk("t5_restart_beats", beats, 5);
    chk("t5_sb_empty", exp_q.size(), 0);
    finish_drain();

    // asynchronous reset mid-drain, off the clock edge
    start_drain(16);
    g = 0;
    while (beats < 4 && g < 40) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk); #3;
    rst = 0;
    #1;
    chk("t6_rst_async", {m_valid, m_last, C_bram_En, busy, drain_done, m_data, C_bram_addr}, '0);
    @(posedge clk); #3;
    rst = 1;
    clear_mon();
    repeat (6) @(posedge clk); #1;
    chk("t6_stay_idle", busy, 0);
    chk("t6_no_en", en_cnt, 0);
    F_done = 0;
    @(posedge clk); #1;
    start_drain(16);
    wait_done(60);
    chk("t6_beats", beats, 16);
    chk("t6_sb_empty", exp_q.size(), 0);
    finish_drain();

    chk("fifo_overflow", ovf, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
